// File: rtl/c_comment_filter.sv
// Strips C line/block comments (each replaced by one space) with one-cycle registered latency.
// Optional whitespace collapse is enabled by defining CFILT_WS_COLLAPSE_EN.
module c_comment_filter (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out,
   output logic       out_valid
);

   typedef enum logic [2:0] {
      NORM,
      SLASH,
      LINE,
      BLK,
      BLK_STAR,
      FLUSH
   } state_t;

   localparam logic [7:0] CH_SLASH = 8'h2F;
   localparam logic [7:0] CH_STAR  = 8'h2A;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_LF    = 8'h0A;

   state_t     state;
   logic [7:0] pend;
   logic [7:0] src;
   logic       accept;
   logic       norm_emit;
   logic [7:0] norm_char;
   logic       repl_emit;

`ifdef CFILT_WS_COLLAPSE_EN
   logic       last_sp;
   logic       src_ws;
`endif

   // FLUSH replays the held character through the same path a fresh NORM input takes.
   always_comb begin
      src    = (state == FLUSH) ? pend : in;
      accept = in_valid && in_ready;
`ifdef CFILT_WS_COLLAPSE_EN
      src_ws    = (src == 8'h20) || (src == 8'h09) || (src == 8'h0D) || (src == 8'h0A);
      norm_emit = !(src_ws && last_sp);
      norm_char = src_ws ? CH_SPACE : src;
      repl_emit = !last_sp;
`else
      norm_emit = 1'b1;
      norm_char = src;
      repl_emit = 1'b1;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= NORM;
         pend      <= 8'h00;
         out       <= 8'h00;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
`ifdef CFILT_WS_COLLAPSE_EN
         last_sp   <= 1'b0;
`endif
      end else begin
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         if (state == FLUSH) begin
            if (norm_emit) begin
               out       <= norm_char;
               out_valid <= 1'b1;
            end
`ifdef CFILT_WS_COLLAPSE_EN
            last_sp <= src_ws;
`endif
            state <= NORM;
         end else if (accept) begin
            case (state)
               NORM: begin
                  if (in == CH_SLASH) begin
                     state <= SLASH;
                  end else begin
                     if (norm_emit) begin
                        out       <= norm_char;
                        out_valid <= 1'b1;
                     end
`ifdef CFILT_WS_COLLAPSE_EN
                     last_sp <= src_ws;
`endif
                  end
               end
               SLASH: begin
                  if (in == CH_SLASH) begin
                     state <= LINE;
                  end else if (in == CH_STAR) begin
                     state <= BLK;
                  end else begin
                     // The held slash goes out now; the new character waits one stalled cycle.
                     out       <= CH_SLASH;
                     out_valid <= 1'b1;
                     pend      <= in;
                     in_ready  <= 1'b0;
                     state     <= FLUSH;
`ifdef CFILT_WS_COLLAPSE_EN
                     last_sp   <= 1'b0;
`endif
                  end
               end
               LINE: begin
                  if (in == CH_LF) begin
                     if (repl_emit) begin
                        out       <= CH_SPACE;
                        out_valid <= 1'b1;
                     end
`ifdef CFILT_WS_COLLAPSE_EN
                     last_sp <= 1'b1;
`endif
                     state <= NORM;
                  end
               end
               BLK: begin
                  if (in == CH_STAR) begin
                     state <= BLK_STAR;
                  end
               end
               BLK_STAR: begin
                  if (in == CH_SLASH) begin
                     if (repl_emit) begin
                        out       <= CH_SPACE;
                        out_valid <= 1'b1;
                     end
`ifdef CFILT_WS_COLLAPSE_EN
                     last_sp <= 1'b1;
`endif
                     state <= NORM;
                  end else if (in != CH_STAR) begin
                     state <= BLK;
                  end
               end
               default: state <= NORM;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_c_comment_filter.sv
// Self-checking bench for c_comment_filter: directed scenarios plus random streams
// compared against a string-level comment-stripping reference model.
module tb_c_comment_filter;

   typedef logic [7:0] byte_q_t[$];

   logic       clk;
   logic       reset;
   logic [7:0] in;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out;
   logic       out_valid;

   int         checks;
   int         errors;
   byte_q_t    outQ;

   c_comment_filter dut (
      .clk       (clk),
      .reset     (reset),
      .in        (in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (out),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   // Collect every emitted character for whole-stream comparison.
   always @(negedge clk) begin
      if (reset && out_valid) outQ.push_back(out);
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic byte_q_t toQ(input string s);
      byte_q_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   function automatic bit isWs(input logic [7:0] c);
      return (c == 8'h20) || (c == 8'h09) || (c == 8'h0D) || (c == 8'h0A);
   endfunction

   // Strip comments by scanning for terminators, then apply the whitespace policy.
   function automatic byte_q_t refModel(input byte_q_t s);
      byte_q_t tok;
      bit      repl[$];
      byte_q_t res;
      int      i;
      int      j;
      bit      lastSp;
      bit      found;
      i = 0;
      while (i < s.size()) begin
         if (s[i] == "/") begin
            if (i + 1 >= s.size()) break;
            if (s[i+1] == "/") begin
               j = i + 2;
               while (j < s.size() && s[j] != 8'h0A) j++;
               if (j >= s.size()) break;
               tok.push_back(8'h20); repl.push_back(1'b1);
               i = j + 1;
               continue;
            end
            if (s[i+1] == "*") begin
               found = 1'b0;
               j = i + 2;
               while (j + 1 < s.size()) begin
                  if (s[j] == "*" && s[j+1] == "/") begin
                     found = 1'b1;
                     break;
                  end
                  j++;
               end
               if (!found) break;
               tok.push_back(8'h20); repl.push_back(1'b1);
               i = j + 2;
               continue;
            end
         end
         tok.push_back(s[i]); repl.push_back(1'b0);
         i++;
      end
      lastSp = 1'b0;
      for (int k = 0; k < tok.size(); k++) begin
`ifdef CFILT_WS_COLLAPSE_EN
         if (repl[k] || isWs(tok[k])) begin
            if (!lastSp) res.push_back(8'h20);
            lastSp = 1'b1;
         end else begin
            res.push_back(tok[k]);
            lastSp = 1'b0;
         end
`else
         res.push_back(tok[k]);
`endif
      end
      return res;
   endfunction

   // Starts and ends at a falling edge; returns on the falling edge after acceptance.
   task automatic sendChar(input logic [7:0] c);
      bit acc;
      int tries;
      in       = c;
      in_valid = 1'b1;
      tries    = 0;
      forever begin
         acc = in_ready;
         @(posedge clk);
         if (acc) break;
         tries++;
         if (tries > 8) begin
            checks++;
            errors++;
            $display("[TB] FAIL stall_timeout observed in_ready 0 expected 1");
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic doReset();
      reset    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      outQ.delete();
   endtask

   task automatic applyStimulus(input byte_q_t q, input bit gaps);
      foreach (q[k]) begin
         sendChar(q[k]);
         if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
   endtask

   task automatic compareStream(input string tag, input byte_q_t exp);
      idle(3);
      checkOutput({tag, "_count"}, outQ.size(), exp.size());
      for (int k = 0; k < exp.size() && k < outQ.size(); k++)
         checkOutput($sformatf("%s_char%0d", tag, k), outQ[k], exp[k]);
   endtask

   initial begin
      byte_q_t stim;
      byte_q_t expQ;
      logic [7:0] alpha[10];
      clk      = 1'b0;
      reset    = 1'b0;
      in       = 8'h00;
      in_valid = 1'b0;
      checks   = 0;
      errors   = 0;
      alpha = '{8'h61, 8'h2F, 8'h2A, 8'h20, 8'h0A, 8'h09, 8'h78, 8'hA5, 8'h3B, 8'h0D};

      repeat (2) @(negedge clk);
      checkOutput("reset_out", out, 8'h00);
      checkOutput("reset_out_valid", out_valid, 1'b0);
      checkOutput("reset_in_ready", in_ready, 1'b1);
      reset = 1'b1;
      outQ.delete();

      $display("[TB] plain text");
      stim = toQ("int a;");
      foreach (stim[k]) begin
         sendChar(stim[k]);
         checkOutput($sformatf("plain_valid%0d", k), out_valid, 1'b1);
         checkOutput($sformatf("plain_char%0d", k), out, stim[k]);
      end
      idle(1);
      checkOutput("plain_idle_valid", out_valid, 1'b0);
      compareStream("plain", toQ("int a;"));

      $display("[TB] block comment");
      doReset();
      stim = toQ("int/*x*/b;");
      foreach (stim[k]) begin
         sendChar(stim[k]);
         if (k >= 3 && k <= 6)
            checkOutput($sformatf("blk_quiet%0d", k), out_valid, 1'b0);
      end
      compareStream("blk", toQ("int b;"));

      $display("[TB] line comment");
      doReset();
      stim = toQ("a // q\nb");
      applyStimulus(stim, 1'b0);
`ifdef CFILT_WS_COLLAPSE_EN
      compareStream("line", toQ("a b"));
`else
      compareStream("line", toQ("a  b"));
`endif

      $display("[TB] slash flush");
      doReset();
      sendChar("a");
      sendChar("/");
      checkOutput("flush_slash_held", out_valid, 1'b0);
      sendChar("b");
      checkOutput("flush_slash_out", out, "/");
      checkOutput("flush_slash_valid", out_valid, 1'b1);
      checkOutput("flush_stall", in_ready, 1'b0);
      in = "c";
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("flush_b_out", out, "b");
      checkOutput("flush_b_valid", out_valid, 1'b1);
      checkOutput("flush_ready_back", in_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      checkOutput("flush_c_out", out, "c");
      checkOutput("flush_c_valid", out_valid, 1'b1);
      compareStream("flush", toQ("a/bc"));

      $display("[TB] star self-loop");
      doReset();
      applyStimulus(toQ("/* **/x"), 1'b0);
      compareStream("star", toQ(" x"));

      $display("[TB] reset inside block comment");
      doReset();
      applyStimulus(toQ("x/*ab"), 1'b0);
      checkOutput("blkrst_hold_out", out, "x");
      checkOutput("blkrst_hold_valid", out_valid, 1'b0);
      #2 reset = 1'b0;
      #1;
      checkOutput("blkrst_out", out, 8'h00);
      checkOutput("blkrst_valid", out_valid, 1'b0);
      checkOutput("blkrst_ready", in_ready, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      outQ.delete();
      applyStimulus(toQ("int"), 1'b0);
      compareStream("blkrst", toQ("int"));

      $display("[TB] random streams");
      for (int t = 0; t < 8; t++) begin
         doReset();
         stim.delete();
         for (int k = 0; k < 40; k++) stim.push_back(alpha[$urandom_range(0, 9)]);
         applyStimulus(stim, 1'b1);
         expQ = refModel(stim);
         compareStream($sformatf("rand%0d", t), expQ);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
